// File: rtl/iter_divider_if.sv
// Request/response channel between the execute stage and the iterative divider.
// The execute stage is the master; the divider is the slave.
interface iter_divider_if #(
  parameter int REG_W = 64
);
  logic             req_valid;
  logic             req_ready;
  logic             req_signed;
  logic [1:0]       req_bmd;
  logic [REG_W-1:0] req_dividend;
  logic [REG_W-1:0] req_divisor;
  logic             resp_valid;
  logic             resp_ready;
  logic [REG_W-1:0] resp_quot;
  logic [REG_W-1:0] resp_rem;
  logic             resp_div0;
  logic             resp_ovf;

  modport master (
    output req_valid, req_signed, req_bmd, req_dividend, req_divisor, resp_ready,
    input  req_ready, resp_valid, resp_quot, resp_rem, resp_div0, resp_ovf
  );

  modport slave (
    input  req_valid, req_signed, req_bmd, req_dividend, req_divisor, resp_ready,
    output req_ready, resp_valid, resp_quot, resp_rem, resp_div0, resp_ovf
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider for MIOP_DIV/MIOP_DIVI: 8/16/32/64-bit operands,
// signed (truncating) or unsigned, one quotient bit per cycle.
module iter_divider #(
  parameter int REG_W = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  iter_divider_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [6:0] bmd_width(input logic [1:0] bmd);
    case (bmd)
      2'd0:    bmd_width = 7'd8;
      2'd1:    bmd_width = 7'd16;
      2'd2:    bmd_width = 7'd32;
      default: bmd_width = 7'd64;
    endcase
  endfunction

  function automatic logic [REG_W-1:0] bmd_mask(input logic [1:0] bmd);
    case (bmd)
      2'd0:    bmd_mask = {{(REG_W-8){1'b0}},  {8{1'b1}}};
      2'd1:    bmd_mask = {{(REG_W-16){1'b0}}, {16{1'b1}}};
      2'd2:    bmd_mask = {{(REG_W-32){1'b0}}, {32{1'b1}}};
      default: bmd_mask = {REG_W{1'b1}};
    endcase
  endfunction

  // Truncate to the operand width, then sign- or zero-extend from bit W-1.
  function automatic logic [REG_W-1:0] extend(input logic [REG_W-1:0] v,
                                              input logic [1:0] bmd,
                                              input logic sgn);
    logic [REG_W-1:0] m;
    logic [REG_W-1:0] top;
    m      = bmd_mask(bmd);
    top    = m ^ (m >> 1);
    extend = (sgn && (|(v & top))) ? (v | ~m) : (v & m);
  endfunction

  logic [1:0]       state_r;
  logic             req_ready_r;
  logic             resp_valid_r;
  logic [REG_W-1:0] resp_quot_r;
  logic [REG_W-1:0] resp_rem_r;
  logic             resp_div0_r;
  logic             resp_ovf_r;

  logic [REG_W-1:0] dvd_r;
  logic [REG_W-1:0] dvs_r;
  logic [REG_W-1:0] rem_r;
  logic [REG_W-1:0] quo_r;
  logic [6:0]       cnt_r;
  logic [1:0]       bmd_r;
  logic             signed_r;
  logic             sgn_q_r;
  logic             sgn_rem_r;
  logic             special_r;
  logic             div0_r;
  logic             ovf_r;

  logic [REG_W-1:0] mask_s;
  logic [REG_W-1:0] top_s;
  logic [REG_W-1:0] dvd_t_s;
  logic [REG_W-1:0] dvs_t_s;
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic [REG_W-1:0] dvd_mag_s;
  logic [REG_W-1:0] dvs_mag_s;
  logic [REG_W-1:0] dvd_align_s;
  logic [6:0]       width_s;
  logic             div0_s;
  logic             ovf_s;
  logic [REG_W:0]   rem_sh_s;
  logic [REG_W:0]   diff_s;
  logic             keep_s;
  logic [REG_W-1:0] fin_quot_s;
  logic [REG_W-1:0] fin_rem_s;

  // Operand preparation for a request being accepted in IDLE.
  always_comb begin
    mask_s      = bmd_mask(bus.req_bmd);
    top_s       = mask_s ^ (mask_s >> 1);
    width_s     = bmd_width(bus.req_bmd);
    dvd_t_s     = bus.req_dividend & mask_s;
    dvs_t_s     = bus.req_divisor & mask_s;
    dvd_neg_s   = bus.req_signed & (|(dvd_t_s & top_s));
    dvs_neg_s   = bus.req_signed & (|(dvs_t_s & top_s));
    dvd_mag_s   = dvd_neg_s ? ((-dvd_t_s) & mask_s) : dvd_t_s;
    dvs_mag_s   = dvs_neg_s ? ((-dvs_t_s) & mask_s) : dvs_t_s;
    // Left-align so the operand's MSB is always shifted out of bit REG_W-1.
    dvd_align_s = dvd_mag_s << (7'd64 - width_s);
    div0_s      = (dvs_t_s == {REG_W{1'b0}});
    ovf_s       = bus.req_signed && (dvd_t_s == top_s) && (dvs_t_s == mask_s);
  end

  // One restoring step plus the final sign correction and extension.
  always_comb begin
    rem_sh_s   = {rem_r, dvd_r[REG_W-1]};
    diff_s     = rem_sh_s - {1'b0, dvs_r};
    keep_s     = rem_sh_s[REG_W] | ~diff_s[REG_W];
    fin_quot_s = special_r ? quo_r
                           : extend(sgn_q_r ? -quo_r : quo_r, bmd_r, signed_r);
    fin_rem_s  = special_r ? rem_r
                           : extend(sgn_rem_r ? -rem_r : rem_r, bmd_r, signed_r);
  end

  // Control FSM, iteration datapath and registered response.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_quot_r  <= {REG_W{1'b0}};
      resp_rem_r   <= {REG_W{1'b0}};
      resp_div0_r  <= 1'b0;
      resp_ovf_r   <= 1'b0;
      dvd_r        <= {REG_W{1'b0}};
      dvs_r        <= {REG_W{1'b0}};
      rem_r        <= {REG_W{1'b0}};
      quo_r        <= {REG_W{1'b0}};
      cnt_r        <= 7'd0;
      bmd_r        <= 2'd0;
      signed_r     <= 1'b0;
      sgn_q_r      <= 1'b0;
      sgn_rem_r    <= 1'b0;
      special_r    <= 1'b0;
      div0_r       <= 1'b0;
      ovf_r        <= 1'b0;
    end else if (flush) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            state_r     <= ST_CALC;
            req_ready_r <= 1'b0;
            bmd_r       <= bus.req_bmd;
            signed_r    <= bus.req_signed;
            sgn_q_r     <= dvd_neg_s ^ dvs_neg_s;
            sgn_rem_r   <= dvd_neg_s;
            dvd_r       <= dvd_align_s;
            dvs_r       <= dvs_mag_s;
            // Exceptional results are preloaded and emitted one cycle later.
            if (div0_s) begin
              special_r <= 1'b1;
              div0_r    <= 1'b1;
              ovf_r     <= 1'b0;
              cnt_r     <= 7'd0;
              quo_r     <= {REG_W{1'b1}};
              rem_r     <= extend(dvd_t_s, bus.req_bmd, bus.req_signed);
            end else if (ovf_s) begin
              special_r <= 1'b1;
              div0_r    <= 1'b0;
              ovf_r     <= 1'b1;
              cnt_r     <= 7'd0;
              quo_r     <= extend(top_s, bus.req_bmd, 1'b1);
              rem_r     <= {REG_W{1'b0}};
            end else begin
              special_r <= 1'b0;
              div0_r    <= 1'b0;
              ovf_r     <= 1'b0;
              cnt_r     <= width_s;
              quo_r     <= {REG_W{1'b0}};
              rem_r     <= {REG_W{1'b0}};
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ST_CALC: begin
          if (cnt_r != 7'd0) begin
            rem_r <= keep_s ? diff_s[REG_W-1:0] : rem_sh_s[REG_W-1:0];
            quo_r <= {quo_r[REG_W-2:0], keep_s};
            dvd_r <= dvd_r << 1;
            cnt_r <= cnt_r - 7'd1;
          end else begin
            state_r      <= ST_DONE;
            resp_valid_r <= 1'b1;
            resp_quot_r  <= fin_quot_s;
            resp_rem_r   <= fin_rem_s;
            resp_div0_r  <= div0_r;
            resp_ovf_r   <= ovf_r;
          end
        end
        ST_DONE: begin
          if (bus.resp_ready) begin
            state_r      <= ST_IDLE;
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
          end else begin
            resp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_quot  = resp_quot_r;
  assign bus.resp_rem   = resp_rem_r;
  assign bus.resp_div0  = resp_div0_r;
  assign bus.resp_ovf   = resp_ovf_r;

endmodule
